// File: rtl/multicycle_pkg.sv
// multicycle_pkg: shared constants for the multi-cycle MIPS control unit.
//   - opcode and funct field values
//   - 4-bit ALU operation codes; they are zero-extended wherever the ALU op
//     port is wider
//   - the FSM state encoding, which is also exported on state_o for debug
package multicycle_pkg;

  // Opcodes
  localparam logic [5:0] OP_R     = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_SLTIU = 6'd11;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_XORI  = 6'd14;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  // R-type funct values
  localparam logic [5:0] FN_SLL  = 6'd0;
  localparam logic [5:0] FN_SRL  = 6'd2;
  localparam logic [5:0] FN_SRA  = 6'd3;
  localparam logic [5:0] FN_ADD  = 6'd32;
  localparam logic [5:0] FN_ADDU = 6'd33;
  localparam logic [5:0] FN_SUB  = 6'd34;
  localparam logic [5:0] FN_SUBU = 6'd35;
  localparam logic [5:0] FN_AND  = 6'd36;
  localparam logic [5:0] FN_OR   = 6'd37;
  localparam logic [5:0] FN_XOR  = 6'd38;
  localparam logic [5:0] FN_SLT  = 6'd42;
  localparam logic [5:0] FN_SLTU = 6'd43;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_ADDU = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_SUBU = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_SLT  = 4'd10;
  localparam logic [3:0] ALU_SLTU = 4'd11;
  localparam logic [3:0] ALU_NOP  = 4'd15;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_EXEC      = 4'd3,
    S_ALU_WB    = 4'd4,
    S_MEM_ADDR  = 4'd5,
    S_MEM_READ  = 4'd6,
    S_MEM_WB    = 4'd7,
    S_MEM_WRITE = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ILLEGAL   = 4'd11
  } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational op/funct decoder for the multi-cycle control.
// Ports:
//   op, funct     in   instruction opcode and funct fields
//   alu_op        out  ALU operation (NOP for instructions that do not use EXEC)
//   shamt_sel     out  shift-amount operand select for sll/srl/sra
//   imm_zero_ext  out  zero-extend the immediate (andi/ori/xori)
//   is_rtype      out  opcode is R-type
//   legal         out  instruction is recognised (R-type also needs a known funct)
module alu_op_decode
  import multicycle_pkg::*;
#(
  parameter int ALUOP_W = 4
) (
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               shamt_sel,
  output logic               imm_zero_ext,
  output logic               is_rtype,
  output logic               legal
);

  logic [3:0] code;

  always_comb begin
    code         = ALU_NOP;
    shamt_sel    = 1'b0;
    imm_zero_ext = 1'b0;
    is_rtype     = 1'b0;
    legal        = 1'b0;
    case (op)
      OP_R: begin
        is_rtype = 1'b1;
        legal    = 1'b1;
        case (funct)
          FN_SLL:  begin code = ALU_SLL; shamt_sel = 1'b1; end
          FN_SRL:  begin code = ALU_SRL; shamt_sel = 1'b1; end
          FN_SRA:  begin code = ALU_SRA; shamt_sel = 1'b1; end
          FN_ADD:  code = ALU_ADD;
          FN_ADDU: code = ALU_ADDU;
          FN_SUB:  code = ALU_SUB;
          FN_SUBU: code = ALU_SUBU;
          FN_AND:  code = ALU_AND;
          FN_OR:   code = ALU_OR;
          FN_XOR:  code = ALU_XOR;
          FN_SLT:  code = ALU_SLT;
          FN_SLTU: code = ALU_SLTU;
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI:  begin code = ALU_ADD;  legal = 1'b1; end
      OP_ADDIU: begin code = ALU_ADDU; legal = 1'b1; end
      OP_SLTI:  begin code = ALU_SLT;  legal = 1'b1; end
      OP_SLTIU: begin code = ALU_SLTU; legal = 1'b1; end
      OP_ANDI:  begin code = ALU_AND;  legal = 1'b1; imm_zero_ext = 1'b1; end
      OP_ORI:   begin code = ALU_OR;   legal = 1'b1; imm_zero_ext = 1'b1; end
      OP_XORI:  begin code = ALU_XOR;  legal = 1'b1; imm_zero_ext = 1'b1; end
      OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: legal = 1'b1;
      default: ;
    endcase
  end

  // Zero-extend the 4-bit code to the configured width.
  always_comb begin
    alu_op      = '0;
    alu_op[3:0] = code;
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore-FSM control unit for the multi-cycle MIPS datapath.
// One instruction takes 3-5 states; every datapath enable/select is a function
// of the registered state plus op/funct.
// Ports:
//   clk, reset       clock; asynchronous active-high reset (forces IDLE)
//   run              level, permits fetching new instructions
//   op, funct        instruction register fields
//   mem_ready        memory completion (only with MULTCTL_MEM_WAIT_EN)
//   pc_write ... imm_zero_ext, alu_src_b, pc_source, alu_op   datapath controls
//   instr_done       pulse in the last state of each instruction
//   illegal          high while trapped in ILLEGAL
//   state_o          current state encoding, for debug
// Handshake: run is a level; it is sampled in IDLE, in every terminal state
// and in ILLEGAL. With MULTCTL_MEM_WAIT_EN defined, FETCH, MEM_READ and
// MEM_WRITE hold until mem_ready is high (a valid/ready-style completion);
// the one-shot enables are qualified by mem_ready and a WAIT_TIMEOUT-cycle
// watchdog sends a stuck access to ILLEGAL. Without the macro mem_ready is
// ignored and each memory state lasts exactly one cycle.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int ALUOP_W      = 4,
  parameter int WAIT_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               branch_ne,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic               shamt_sel,
  output logic               imm_zero_ext,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_source,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               instr_done,
  output logic               illegal,
  output logic [3:0]         state_o
);

  state_t state_q, state_d;

  logic [ALUOP_W-1:0] dec_alu_op;
  logic               dec_shamt_sel;
  logic               dec_imm_zero_ext;
  logic               dec_is_rtype;
  logic               dec_legal;

  alu_op_decode #(.ALUOP_W(ALUOP_W)) u_alu_op_decode (
    .op           (op),
    .funct        (funct),
    .alu_op       (dec_alu_op),
    .shamt_sel    (dec_shamt_sel),
    .imm_zero_ext (dec_imm_zero_ext),
    .is_rtype     (dec_is_rtype),
    .legal        (dec_legal)
  );

  function automatic logic [ALUOP_W-1:0] ext_op(input logic [3:0] c);
    ext_op      = '0;
    ext_op[3:0] = c;
  endfunction

`ifdef MULTCTL_MEM_WAIT_EN
  localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             wait_expired;

  // Counts cycles already spent in the current memory state without mem_ready.
  assign wait_expired = (wait_cnt_q == CNT_W'(WAIT_TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wait_cnt_q <= '0;
    else       wait_cnt_q <= wait_cnt_d;
  end
`else
  logic unused_mem_ready;
  localparam int UNUSED_WAIT_TIMEOUT = WAIT_TIMEOUT;
  assign unused_mem_ready = mem_ready;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    shamt_sel     = 1'b0;
    imm_zero_ext  = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    alu_op        = '0;
    instr_done    = 1'b0;
    illegal       = 1'b0;
`ifdef MULTCTL_MEM_WAIT_EN
    wait_cnt_d    = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = ext_op(ALU_ADD);
`ifdef MULTCTL_MEM_WAIT_EN
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready)         state_d = S_DECODE;
        else if (wait_expired) state_d = S_ILLEGAL;
`else
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        state_d   = S_DECODE;
`endif
      end
      S_DECODE: begin
        // Branch target is computed speculatively here, before op is known.
        alu_src_b = 2'b11;
        alu_op    = ext_op(ALU_ADD);
        if (!dec_legal) begin
          state_d = S_ILLEGAL;
        end else begin
          case (op)
            OP_LW, OP_SW:   state_d = S_MEM_ADDR;
            OP_BEQ, OP_BNE: state_d = S_BRANCH;
            OP_J:           state_d = S_JUMP;
            default:        state_d = S_EXEC;
          endcase
        end
      end
      S_EXEC: begin
        alu_src_a    = 1'b1;
        alu_src_b    = dec_is_rtype ? 2'b00 : 2'b10;
        shamt_sel    = dec_shamt_sel;
        imm_zero_ext = dec_imm_zero_ext;
        alu_op       = dec_alu_op;
        state_d      = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        reg_dst    = dec_is_rtype;
        instr_done = 1'b1;
        state_d    = run ? S_FETCH : S_IDLE;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ext_op(ALU_ADD);
        state_d   = (op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
`ifdef MULTCTL_MEM_WAIT_EN
        if (mem_ready)         state_d = S_MEM_WB;
        else if (wait_expired) state_d = S_ILLEGAL;
`else
        state_d  = S_MEM_WB;
`endif
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = run ? S_FETCH : S_IDLE;
      end
      S_MEM_WRITE: begin
        iord = 1'b1;
`ifdef MULTCTL_MEM_WAIT_EN
        mem_write  = mem_ready;
        instr_done = mem_ready;
        if (mem_ready)         state_d = run ? S_FETCH : S_IDLE;
        else if (wait_expired) state_d = S_ILLEGAL;
`else
        mem_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = run ? S_FETCH : S_IDLE;
`endif
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ext_op(ALU_SUB);
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        branch_ne     = (op == OP_BNE);
        instr_done    = 1'b1;
        state_d       = run ? S_FETCH : S_IDLE;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
        state_d    = run ? S_FETCH : S_IDLE;
      end
      S_ILLEGAL: begin
        // Leaving the trap needs run to be dropped, so a free-running run
        // cannot silently skip past a bad instruction.
        illegal = 1'b1;
        if (!run) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef MULTCTL_MEM_WAIT_EN
    // Reload on entry to a memory state, count while it is held.
    if ((state_d == state_q) &&
        (state_q == S_FETCH || state_q == S_MEM_READ || state_q == S_MEM_WRITE))
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
`endif
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control. The expected behaviour of each instruction is
// produced as a per-cycle trace (state number plus every output) from lookup
// tables of the instruction set, and compared cycle by cycle with the DUT.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [5:0] op;
  logic [5:0] funct;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write;
  logic       ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, shamt_sel;
  logic       imm_zero_ext, instr_done, illegal;
  logic [1:0] alu_src_b, pc_source;
  logic [3:0] alu_op;
  logic [3:0] state_o;

  multicycle_control #(.ALUOP_W(4), .WAIT_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .run(run), .op(op), .funct(funct),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .branch_ne(branch_ne), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .shamt_sel(shamt_sel), .imm_zero_ext(imm_zero_ext), .alu_src_b(alu_src_b),
    .pc_source(pc_source), .alu_op(alu_op), .instr_done(instr_done),
    .illegal(illegal), .state_o(state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write;
    logic ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, shamt_sel;
    logic imm_zero_ext;
    logic [1:0] alu_src_b, pc_source;
    logic [3:0] alu_op;
    logic instr_done, illegal;
  } obs_t;
  localparam int OBS_W = $bits(obs_t);

  // ---------------- scoreboard ----------------
  logic [OBS_W-1:0] exp_q[$];
  logic             run_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  bit mr_auto = 1'b1;

  int r_funct_tab[12] = '{0, 2, 3, 32, 33, 34, 35, 36, 37, 38, 42, 43};
  int r_alu_tab[12]   = '{7, 8, 9, 0, 1, 2, 3, 4, 5, 6, 10, 11};
  int imm_alu_tab[7]  = '{0, 1, 10, 11, 4, 5, 6};   // opcodes 8..14
  int legal_ops[13]   = '{0, 2, 4, 5, 8, 9, 10, 11, 12, 13, 14, 35, 43};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.st = state_o; o.pc_write = pc_write; o.pc_write_cond = pc_write_cond;
    o.branch_ne = branch_ne; o.iord = iord; o.mem_read = mem_read;
    o.mem_write = mem_write; o.ir_write = ir_write; o.reg_dst = reg_dst;
    o.mem_to_reg = mem_to_reg; o.reg_write = reg_write; o.alu_src_a = alu_src_a;
    o.shamt_sel = shamt_sel; o.imm_zero_ext = imm_zero_ext;
    o.alu_src_b = alu_src_b; o.pc_source = pc_source; o.alu_op = alu_op;
    o.instr_done = instr_done; o.illegal = illegal;
    return o;
  endfunction

  function automatic obs_t st(input int s);
    obs_t o = '0;
    o.st = 4'(s);
    return o;
  endfunction

  function automatic obs_t fetch_obs();
    obs_t x = st(1);
    x.mem_read = 1'b1; x.ir_write = 1'b1; x.pc_write = 1'b1; x.alu_src_b = 2'd1;
    return x;
  endfunction

  task automatic push(input obs_t x, input logic r);
    exp_q.push_back(x);
    run_q.push_back(r);
  endtask

  // Reference model: expected cycle trace for one instruction. Each entry
  // also carries the run level to apply after that cycle has been checked.
  task automatic plan(input logic [5:0] o, input logic [5:0] f, input bit keep_run);
    obs_t x;
    int   ridx = -1;
    int   n;
    for (int i = 0; i < 12; i++) if (int'(f) == r_funct_tab[i]) ridx = i;
    push(fetch_obs(), 1'($urandom_range(0, 1)));
    x = st(2); x.alu_src_b = 2'd3;
    push(x, 1'($urandom_range(0, 1)));
    if ((o == 6'd0 && ridx >= 0) || (o >= 6'd8 && o <= 6'd14)) begin
      x = st(3); x.alu_src_a = 1'b1;
      x.alu_src_b    = (o == 6'd0) ? 2'd0 : 2'd2;
      x.shamt_sel    = (o == 6'd0) && (f < 6'd4);
      x.imm_zero_ext = (o >= 6'd12);
      x.alu_op       = (o == 6'd0) ? 4'(r_alu_tab[ridx]) : 4'(imm_alu_tab[int'(o) - 8]);
      push(x, 1'($urandom_range(0, 1)));
      x = st(4); x.reg_write = 1'b1; x.reg_dst = (o == 6'd0); x.instr_done = 1'b1;
      push(x, keep_run);
    end else if (o == 6'd35 || o == 6'd43) begin
      x = st(5); x.alu_src_a = 1'b1; x.alu_src_b = 2'd2;
      push(x, 1'($urandom_range(0, 1)));
      if (o == 6'd35) begin
        x = st(6); x.mem_read = 1'b1; x.iord = 1'b1;
        push(x, 1'($urandom_range(0, 1)));
        x = st(7); x.reg_write = 1'b1; x.mem_to_reg = 1'b1; x.instr_done = 1'b1;
        push(x, keep_run);
      end else begin
        x = st(8); x.mem_write = 1'b1; x.iord = 1'b1; x.instr_done = 1'b1;
        push(x, keep_run);
      end
    end else if (o == 6'd4 || o == 6'd5) begin
      x = st(9); x.alu_src_a = 1'b1; x.alu_op = 4'd2; x.pc_write_cond = 1'b1;
      x.pc_source = 2'd1; x.branch_ne = (o == 6'd5); x.instr_done = 1'b1;
      push(x, keep_run);
    end else if (o == 6'd2) begin
      x = st(10); x.pc_write = 1'b1; x.pc_source = 2'd2; x.instr_done = 1'b1;
      push(x, keep_run);
    end else begin
      // Trap: stays while run is high, leaves one cycle after run drops.
      n = $urandom_range(1, 3);
      x = st(11); x.illegal = 1'b1;
      for (int i = 1; i < n; i++) push(x, 1'b1);
      push(x, 1'b0);
      push(st(0), 1'b0);
      return;
    end
    if (!keep_run) push(st(0), 1'b0);
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
`ifdef MULTCTL_MEM_WAIT_EN
    if (mr_auto) mem_ready = 1'b1;
`else
    if (mr_auto) mem_ready = 1'($urandom_range(0, 1));
`endif
  endtask

  // Called one step after an edge while the DUT is in IDLE or in the final
  // cycle of the previous instruction with run high.
  task automatic do_instr(input logic [5:0] o, input logic [5:0] f, input bit keep_run);
    obs_t e;
    op = o; funct = f; run = 1'b1;
    plan(o, f, keep_run);
    while (exp_q.size() > 0) begin
      tick();
      e = obs_t'(exp_q.pop_front());
      check_val($sformatf("op%0d_f%0d_st%0d", o, f, e.st), 32'(sample()), 32'(e));
      run = run_q.pop_front();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    obs_t x;
    logic [5:0] ro, rf;
    reset = 1'b1; run = 1'b0; op = '0; funct = '0; mem_ready = 1'b0;
    #2;
    check_val("reset_state", 32'(sample()), 32'(st(0)));
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    tick();
    check_val("idle_after_reset", 32'(sample()), 32'(st(0)));

    // Directed: add, lw then sw back-to-back, bne, undefined opcode.
    do_instr(6'd0, 6'd32, 1'b0);
    do_instr(6'd35, 6'd0, 1'b1);
    do_instr(6'd43, 6'd0, 1'b0);
    do_instr(6'd5, 6'd0, 1'b0);
    do_instr(6'd63, 6'd0, 1'b0);
    do_instr(6'd0, 6'd1, 1'b0);    // R-type with undefined funct

    // Reset in the middle of MEM_READ clears everything before the next edge.
    op = 6'd35; funct = '0; run = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check_val("pre_reset_state", 32'(state_o), 32'd6);
    reset = 1'b1;
    #1;
    check_val("reset_async", 32'(sample()), 32'(st(0)));
    run = 1'b0;
    tick();
    check_val("reset_held", 32'(sample()), 32'(st(0)));
    reset = 1'b0;
    tick();
    check_val("idle_after_abort", 32'(sample()), 32'(st(0)));

    // Randomized instruction stream.
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 4) != 0) ro = 6'(legal_ops[$urandom_range(0, 12)]);
      else                           ro = 6'($urandom_range(0, 63));
      if (ro == 6'd0 && $urandom_range(0, 4) != 0) rf = 6'(r_funct_tab[$urandom_range(0, 11)]);
      else                                         rf = 6'($urandom_range(0, 63));
      do_instr(ro, rf, 1'($urandom_range(0, 1)));
    end
    if (run) begin
      run = 1'b0;
      tick();
      check_val("final_idle", 32'(sample()), 32'(st(0)));
    end

`ifdef MULTCTL_MEM_WAIT_EN
    // FETCH held by three cycles of mem_ready low.
    mr_auto = 1'b0; mem_ready = 1'b0;
    op = 6'd0; funct = 6'd32; run = 1'b1;
    x = fetch_obs(); x.ir_write = 1'b0; x.pc_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val($sformatf("wait_fetch%0d", i + 1), 32'(sample()), 32'(x));
    end
    tick();
    mem_ready = 1'b1;
    #1;
    check_val("wait_fetch4", 32'(sample()), 32'(fetch_obs()));
    tick();
    check_val("wait_decode", 32'(state_o), 32'd2);
    run = 1'b0;
    tick(); tick(); tick();
    check_val("wait_idle", 32'(state_o), 32'd0);
    // mem_ready never arrives: trap after WAIT_TIMEOUT cycles.
    mem_ready = 1'b0; run = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    check_val("timeout_fetch16", 32'(state_o), 32'd1);
    tick();
    check_val("timeout_illegal", 32'(state_o), 32'd11);
    run = 1'b0;
    tick();
    check_val("timeout_idle", 32'(state_o), 32'd0);
`else
    x = '0;
    mr_auto = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
